// File: rtl/fp_pkg.sv
// Shared single-precision FP constants and the normalize-stage payload type.
`default_nettype none

package fp_pkg;

    localparam logic [1:0] RM_RNE = 2'b00;
    localparam logic [1:0] RM_RDN = 2'b01;
    localparam logic [1:0] RM_RUP = 2'b10;
    localparam logic [1:0] RM_RTZ = 2'b11;

    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;
    localparam logic [31:0] MAX_FIN = 32'h7F7F_FFFF;

    // Normalized operand held between the normalize and round/pack stages.
    // exp is a 12-bit two's-complement value; headroom covers the +1 from
    // normalization and the +1 from a rounding carry.
    typedef struct packed {
        logic        sign;
        logic [1:0]  rm;
        logic        zero;
        logic [11:0] exp;
        logic [22:0] frac;
        logic        guard;
        logic        sticky;
    } norm_t;

endpackage

`default_nettype wire

// File: rtl/fp_round_inc.sv
// Rounding increment and inexact decision from sign, lsb, guard and sticky.
`default_nettype none

module fp_round_inc
    import fp_pkg::*;
(
    input  logic [1:0] rm_i,
    input  logic       sign_i,
    input  logic       lsb_i,
    input  logic       guard_i,
    input  logic       sticky_i,
    output logic       inc_o,
    output logic       inx_o
);

    always_comb begin
        inx_o = guard_i | sticky_i;
        inc_o = 1'b0;
        case (rm_i)
            RM_RNE:  inc_o = guard_i & (sticky_i | lsb_i);
            RM_RDN:  inc_o = sign_i & (guard_i | sticky_i);
            RM_RUP:  inc_o = ~sign_i & (guard_i | sticky_i);
            default: inc_o = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/fmul_norm_round.sv
// Two-stage normalize / round / pack stage for the binary32 multiplier,
// with a valid/ready handshake and no skid buffer.
`default_nettype none

module fmul_norm_round
    import fp_pkg::*;
#(
    parameter int BIAS = 127,
    parameter int PW   = 52
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] prod,
    input  logic          sign,
    input  logic [9:0]    exp_in,
    input  logic [1:0]    rm,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   result,
    output logic          ovf,
    output logic          unf,
    output logic          inx
);

    localparam logic signed [11:0] EXP_OVF = 12'(2 * BIAS + 1);

    logic        s1_valid_q;
    norm_t       s1_q;
    norm_t       s1_d;
    logic        s2_valid_q;
    logic [31:0] result_q;
    logic [31:0] result_d;
    logic        ovf_q;
    logic        ovf_d;
    logic        unf_q;
    logic        unf_d;
    logic        inx_q;
    logic        inx_d;

    logic        s1_load;
    logic        s2_load;
    logic [11:0] exp_ext;

    logic        rnd_inc;
    logic        rnd_inx;
    logic        rnd_carry;
    logic [22:0] frac_rnd;
    logic signed [11:0] exp_rnd;
    logic        away;

    assign s2_load  = ~s2_valid_q | out_ready;
    assign s1_load  = ~s1_valid_q | s2_load;
    assign in_ready = s1_load;

    assign exp_ext = {{2{exp_in[9]}}, exp_in};

    always_comb begin
        s1_d.sign   = sign;
        s1_d.rm     = rm;
        s1_d.zero   = 1'b0;
        s1_d.exp    = exp_ext;
        s1_d.frac   = '0;
        s1_d.guard  = 1'b0;
        s1_d.sticky = 1'b0;
        if (prod[PW-1]) begin
            s1_d.frac   = prod[PW-2 -: 23];
            s1_d.guard  = prod[PW-25];
            s1_d.sticky = |prod[PW-26:0];
            s1_d.exp    = exp_ext + 12'd1;
        end else if (prod[PW-2]) begin
            s1_d.frac   = prod[PW-3 -: 23];
            s1_d.guard  = prod[PW-26];
            s1_d.sticky = |prod[PW-27:0];
        end else begin
            s1_d.zero   = 1'b1;
        end
    end

    fp_round_inc u_round_inc (
        .rm_i     (s1_q.rm),
        .sign_i   (s1_q.sign),
        .lsb_i    (s1_q.frac[0]),
        .guard_i  (s1_q.guard),
        .sticky_i (s1_q.sticky),
        .inc_o    (rnd_inc),
        .inx_o    (rnd_inx)
    );

    // A carry out of the fraction is a carry out of the 24-bit significand;
    // the fraction then wraps to zero on its own.
    assign {rnd_carry, frac_rnd} = {1'b0, s1_q.frac} + {23'd0, rnd_inc};
    assign exp_rnd = $signed(s1_q.exp) + $signed({11'd0, rnd_carry});

    assign away = (s1_q.rm == RM_RNE) ||
                  ((s1_q.rm == RM_RDN) &&  s1_q.sign) ||
                  ((s1_q.rm == RM_RUP) && !s1_q.sign);

    always_comb begin
        result_d = {s1_q.sign, exp_rnd[7:0], frac_rnd};
        ovf_d    = 1'b0;
        unf_d    = 1'b0;
        inx_d    = rnd_inx;
        if (s1_q.zero) begin
            result_d = {s1_q.sign, 31'd0};
            inx_d    = 1'b0;
        end else if (exp_rnd >= EXP_OVF) begin
            result_d = {s1_q.sign, away ? POS_INF[30:0] : MAX_FIN[30:0]};
            ovf_d    = 1'b1;
            inx_d    = 1'b1;
        end else if (exp_rnd <= 12'sd0) begin
            result_d = {s1_q.sign, 31'd0};
            unf_d    = 1'b1;
            inx_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_valid_q <= 1'b0;
            result_q   <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            inx_q      <= 1'b0;
        end else begin
            if (s1_load) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_q <= s1_d;
                end
            end
            // Output data only changes when a real entry moves in, so a
            // stalled or drained stage keeps its last result stable.
            if (s2_load) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    result_q <= result_d;
                    ovf_q    <= ovf_d;
                    unf_q    <= unf_d;
                    inx_q    <= inx_d;
                end
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign result    = result_q;
    assign ovf       = ovf_q;
    assign unf       = unf_q;
    assign inx       = inx_q;

endmodule

`default_nettype wire

// File: tb/tb_fmul_norm_round.sv
// Randomized and directed self-checking bench for fmul_norm_round.
`default_nettype none

module tb_fmul_norm_round;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [51:0] prod;
    logic        sign;
    logic [9:0]  exp_in;
    logic [1:0]  rm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        ovf;
    logic        unf;
    logic        inx;

    int errors = 0;
    int checks = 0;
    int acc_cnt = 0;
    logic [34:0] exp_q[$];
    logic [34:0] got_q[$];

    always #5 clk = ~clk;

    fmul_norm_round #(.BIAS(127), .PW(52)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .prod      (prod),
        .sign      (sign),
        .exp_in    (exp_in),
        .rm        (rm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .ovf       (ovf),
        .unf       (unf),
        .inx       (inx)
    );

    // Reference: treat the product as an integer, keep the top 24 bits as the
    // significand and round on the value of the discarded remainder.
    function automatic logic [34:0] model(input logic [51:0] p, input logic s,
                                          input logic [9:0] e, input logic [1:0] r);
        longint m, rem, half;
        int     ex;
        bit     inc, inexact, away;
        logic [31:0] res;
        ex = $signed(e);
        if (p[51]) begin
            m = longint'(p >> 28); rem = longint'(p[27:0]); half = 64'd1 << 27; ex = ex + 1;
        end else if (p[50]) begin
            m = longint'(p >> 27); rem = longint'(p[26:0]); half = 64'd1 << 26;
        end else begin
            return {s, 31'd0, 3'b000};
        end
        inexact = (rem != 0);
        case (r)
            2'd0:    inc = (rem > half) || (rem == half && (m % 2) == 1);
            2'd1:    inc = s && inexact;
            2'd2:    inc = !s && inexact;
            default: inc = 1'b0;
        endcase
        m = m + longint'(inc);
        if (m == (64'd1 << 24)) begin
            m = m >> 1;
            ex = ex + 1;
        end
        if (ex >= 255) begin
            away = (r == 2'd0) || (r == 2'd1 && s) || (r == 2'd2 && !s);
            res  = away ? {s, 31'h7F80_0000} : {s, 31'h7F7F_FFFF};
            return {res, 3'b101};
        end
        if (ex <= 0) return {s, 31'd0, 3'b011};
        res = {s, 8'(ex), 23'(m)};
        return {res, 2'b00, inexact};
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready) begin
                exp_q.push_back(model(prod, sign, exp_in, rm));
                acc_cnt++;
            end
            if (out_valid && out_ready) got_q.push_back({result, ovf, unf, inx});
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Inputs change 2 time units after the rising edge; called at that point.
    task automatic send(input logic [51:0] p, input logic s, input logic [9:0] e, input logic [1:0] r);
        int n = 0;
        prod = p; sign = s; exp_in = e; rm = r; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_ready stuck low for %0d cycles", n);
        end
        @(posedge clk); #2;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        prod = {$urandom, $urandom};
        rm = 2'($urandom);
        @(posedge clk); #2;
    endtask

    task automatic rand_op(output logic [51:0] p, output logic s, output logic [9:0] e, output logic [1:0] r);
        int k;
        p = 52'({$urandom, $urandom});
        k = $urandom_range(0, 7);
        p[51:50] = (k == 0) ? 2'b00 : (k < 4) ? 2'b01 : {1'b1, p[50]};
        if ($urandom_range(0, 3) == 0) p[25:0] = '0;
        case ($urandom_range(0, 3))
            0:       e = 10'($urandom_range(0, 10) - 5);
            1:       e = 10'($urandom_range(250, 260));
            2:       e = 10'($urandom_range(1, 254));
            default: e = 10'($urandom);
        endcase
        s = 1'($urandom);
        r = 2'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        prod = '0; sign = 1'b0; exp_in = '0; rm = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({out_valid, result, ovf, unf, inx} !== 36'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h required 0", {out_valid, result, ovf, unf, inx});
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b required 1", in_ready);
        end
        @(posedge clk); #2;
        rst = 1'b0;
        out_ready = 1'b1;
        idle();
    endtask

    task automatic test_directed();
        localparam int N = 12;
        logic [51:0] vp[N];
        logic        vs[N];
        logic [9:0]  ve[N];
        logic [1:0]  vr[N];
        logic [34:0] vx[N];
        logic [51:0] ones50, ones51, tie;
        ones50 = (52'd1 << 50) | (52'h7F_FFFF << 27) | (52'd1 << 26);
        ones51 = (52'd1 << 51) | (52'h7F_FFFF << 28) | (52'd1 << 27);
        tie    = (52'd1 << 50) | (52'd1 << 26);
        vp[0]  = 52'd1 << 50;                   vs[0]  = 0; ve[0]  = 127; vr[0]  = 0; vx[0]  = {32'h3F80_0000, 3'b000};
        vp[1]  = (52'd1 << 51) | (52'd1 << 48); vs[1]  = 0; ve[1]  = 127; vr[1]  = 0; vx[1]  = {32'h4010_0000, 3'b000};
        vp[2]  = tie;                           vs[2]  = 0; ve[2]  = 127; vr[2]  = 0; vx[2]  = {32'h3F80_0000, 3'b001};
        vp[3]  = tie;                           vs[3]  = 0; ve[3]  = 127; vr[3]  = 2; vx[3]  = {32'h3F80_0001, 3'b001};
        vp[4]  = tie;                           vs[4]  = 0; ve[4]  = 127; vr[4]  = 1; vx[4]  = {32'h3F80_0000, 3'b001};
        vp[5]  = ones50;                        vs[5]  = 0; ve[5]  = 253; vr[5]  = 0; vx[5]  = {32'h7F00_0000, 3'b001};
        vp[6]  = ones51;                        vs[6]  = 0; ve[6]  = 254; vr[6]  = 0; vx[6]  = {32'h7F80_0000, 3'b101};
        vp[7]  = ones51;                        vs[7]  = 0; ve[7]  = 254; vr[7]  = 3; vx[7]  = {32'h7F7F_FFFF, 3'b101};
        vp[8]  = 52'd1 << 50;                   vs[8]  = 1; ve[8]  = 0;   vr[8]  = 0; vx[8]  = {32'h8000_0000, 3'b011};
        vp[9]  = 52'h3_FFFF_FFFF_FFFF;          vs[9]  = 1; ve[9]  = 127; vr[9]  = 0; vx[9]  = {32'h8000_0000, 3'b000};
        vp[10] = ones51;                        vs[10] = 0; ve[10] = 254; vr[10] = 1; vx[10] = {32'h7F7F_FFFF, 3'b101};
        vp[11] = ones51;                        vs[11] = 1; ve[11] = 254; vr[11] = 1; vx[11] = {32'hFF80_0000, 3'b101};
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            got_q.delete(); exp_q.delete();
            send(vp[i], vs[i], ve[i], vr[i]);
            in_valid = 1'b0;
            if (i == 0) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL latency_early: out_valid %b after capture edge, required 0", out_valid);
                end
            end
            @(posedge clk); #2;
            if (i == 0) begin
                checks++;
                if (out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL latency_two: out_valid %b on second edge, required 1", out_valid);
                end
            end
            idle(); idle();
            checks++;
            if (got_q.size() != 1) begin
                errors++;
                $display("FAIL directed_%0d_count: got %0d results required 1", i, got_q.size());
            end else if (got_q[0] !== vx[i]) begin
                errors++;
                $display("FAIL directed_%0d: got %h/%b required %h/%b", i,
                         got_q[0][34:3], got_q[0][2:0], vx[i][34:3], vx[i][2:0]);
            end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_backpressure();
        int base;
        logic [34:0] held;
        logic [51:0] p; logic s; logic [9:0] e; logic [1:0] r;
        int n;
        got_q.delete(); exp_q.delete();
        base = acc_cnt;
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    rand_op(p, s, e, r);
                    e = 10'($urandom_range(1, 250));
                    send(p, s, e, r);
                end
                in_valid = 1'b0;
            end
            begin
                repeat (3) @(negedge clk);
                checks++;
                if (in_ready !== 1'b0 || acc_cnt - base != 2) begin
                    errors++;
                    $display("FAIL bp_full: in_ready %b accepted %0d, required 0 and 2", in_ready, acc_cnt - base);
                end
                held = {result, ovf, unf, inx};
                repeat (2) begin
                    @(negedge clk);
                    checks++;
                    if ({result, ovf, unf, inx} !== held || out_valid !== 1'b1) begin
                        errors++;
                        $display("FAIL bp_hold: got %h valid %b, required %h valid 1",
                                 {result, ovf, unf, inx}, out_valid, held);
                    end
                end
                @(posedge clk); #2;
                out_ready = 1'b1;
            end
        join
        n = 0;
        while (got_q.size() < 4 && n < 50) begin
            idle();
            n++;
        end
        checks++;
        if (got_q.size() != 4 || exp_q.size() != 4) begin
            errors++;
            $display("FAIL bp_count: got %0d results from %0d accepted, required 4", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL bp_order_%0d: got %h required %h", i, got_q[i], exp_q[i]);
                end
            end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_random();
        logic [51:0] p; logic s; logic [9:0] e; logic [1:0] r;
        bit done = 0;
        int n;
        got_q.delete(); exp_q.delete();
        fork
            begin
                for (int i = 0; i < 250; i++) begin
                    rand_op(p, s, e, r);
                    send(p, s, e, r);
                    if ($urandom_range(0, 3) == 0) idle();
                end
                in_valid = 1'b0;
                done = 1;
            end
            begin
                while (!done) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk); #2;
                end
                out_ready = 1'b1;
            end
        join
        n = 0;
        while (got_q.size() < exp_q.size() && n < 50) begin
            idle();
            n++;
        end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rand_count: got %0d results required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rand_%0d: got %h/%b required %h/%b", i,
                         got_q[i][34:3], got_q[i][2:0], exp_q[i][34:3], exp_q[i][2:0]);
            end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_midflight();
        logic [51:0] p; logic s; logic [9:0] e; logic [1:0] r;
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rand_op(p, s, e, r);
            send(p, s, e, r);
        end
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_pre: out_valid %b in_ready %b, required 1 and 0", out_valid, in_ready);
        end
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, result, ovf, unf, inx} !== 36'd0) begin
            errors++;
            $display("FAIL rst_async: got %h required 0", {out_valid, result, ovf, unf, inx});
        end
        @(posedge clk); #2;
        rst = 1'b0;
        out_ready = 1'b1;
        got_q.delete(); exp_q.delete();
        repeat (5) idle();
        checks++;
        if (got_q.size() != 0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_flush: emitted %0d out_valid %b in_ready %b, required 0 0 1",
                     got_q.size(), out_valid, in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
